mux_scan_seq: RTL

//   Parametrised, registered N-to-1 multiplexer of W-bit channels. Generalises the

---
 rtl/mux_scan_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mux_scan_seq.sv
// mux_scan_seq: registered N:1 channel mux with manual/scan sequencer; MUX_SCAN_PARITY_EN adds out_par.
// Latency: first beat valid the cycle after an accepted start, then up to one beat per cycle.
// Backpressure: beat held stable while out_valid && !out_ready; next beat loads on the accepting edge.
module mux_scan_seq #(
   parameter int N = 16,
   parameter int W = 8,
   localparam int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N*W-1:0] in_data,
   input  logic           mode,
   input  logic [SW-1:0]  sel,
   input  logic [N-1:0]   ch_mask,
   input  logic           start,
   input  logic           out_ready,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_ch,
   output logic           busy,
   output logic           done
`ifdef MUX_SCAN_PARITY_EN
   ,
   output logic           out_par
`endif
);

   typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

   state_t        state_q, state_d;
   logic          mode_q;
   logic [N-1:0]  mask_q;
   logic [SW-1:0] first_ch, next_ch, load_ch;
   logic          more, load, latch, clr_valid, accept;
   logic [W-1:0]  load_dat;

   assign accept = out_valid && out_ready;
   assign busy   = (state_q != IDLE);
   assign done   = (state_q == FIN);

   // Lowest set bit of the incoming mask, and lowest latched bit above the current beat.
   always_comb begin
      first_ch = '0;
      next_ch  = '0;
      more     = 1'b0;
      for (int i = N-1; i >= 0; i--) begin
         if (ch_mask[i]) first_ch = SW'(i);
         if (mask_q[i] && (i > int'(out_ch))) begin
            next_ch = SW'(i);
            more    = 1'b1;
         end
      end
   end

   // Channel indices at or above N read as zero.
   always_comb begin
      load_dat = '0;
      for (int c = 0; c < N; c++) begin
         if (int'(load_ch) == c) load_dat = in_data[c*W +: W];
      end
   end

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      load_ch   = '0;
      latch     = 1'b0;
      clr_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               latch = 1'b1;
               if (!mode) begin
                  load    = 1'b1;
                  load_ch = sel;
                  state_d = EMIT;
               end else if (|ch_mask) begin
                  load    = 1'b1;
                  load_ch = first_ch;
                  state_d = EMIT;
               end else begin
                  state_d = FIN;
               end
            end
         end
         EMIT: begin
            if (accept) begin
               if (mode_q && more) begin
                  load    = 1'b1;
                  load_ch = next_ch;
               end else begin
                  clr_valid = 1'b1;
                  state_d   = FIN;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q    <= 1'b0;
         mask_q    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
`ifdef MUX_SCAN_PARITY_EN
         out_par   <= 1'b0;
`endif
      end else begin
         if (latch) begin
            mode_q <= mode;
            mask_q <= ch_mask;
         end
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_dat;
            out_ch    <= load_ch;
`ifdef MUX_SCAN_PARITY_EN
            out_par   <= ^load_dat;
`endif
         end else if (clr_valid) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
